// File: rtl/gamepad_scanner.sv
// 8x2 button matrix scanner: row-multiplexed sampling, per-frame debounce (GAMEPAD_DEBOUNCE_EN)
// and a sticky change report on a valid/ready handshake that only clears on transfer.
module gamepad_scanner #(
  parameter int SETTLE_CYCLES  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  output logic [2:0]  row_sel,
  output logic        dec_enable,
  input  logic [1:0]  col_in,
  output logic [15:0] btn_state,
  output logic        chg_valid,
  input  logic        chg_ready,
  output logic [15:0] chg_mask,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_FRAME  = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_cfg
    $error("gamepad_scanner: SETTLE_CYCLES or DEBOUNCE_SCANS out of range");
  end

  logic [2:0]  state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [15:0] btn_q, btn_d;
  logic [15:0] mask_q, mask_d;
  logic        vld_q, vld_d;
  logic        load;
  logic        xfer;
  logic [15:0] diff;

`ifdef GAMEPAD_DEBOUNCE_EN
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  logic [15:0] last_q, last_d;
  logic [3:0]  match_q, match_d;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    btn_d   = btn_q;
    sync1_d = col_in;
    sync2_d = sync1_q;
    load    = 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
    last_d  = last_q;
    match_d = match_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d = ST_DRIVE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      ST_SAMPLE: begin
        frame_d[{row_q, 1'b0} +: 2] = sync2_q;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        cnt_d = 8'd0;
        if (row_q == 3'd7) begin
          state_d = ST_FRAME;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_FRAME: begin
`ifdef GAMEPAD_DEBOUNCE_EN
        // Run length saturates so a stable frame never re-triggers the count.
        if (frame_q == last_q) begin
          if (match_q < DEB) match_d = match_q + 4'd1;
        end else begin
          match_d = 4'd1;
          last_d  = frame_q;
        end
        load = (match_d == DEB);
`else
        load = 1'b1;
`endif
        row_d   = 3'd0;
        cnt_d   = 8'd0;
        state_d = scan_en ? ST_DRIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) btn_d = frame_q;
  end

  // A diff landing on the transfer cycle starts the next report instead of being lost.
  always_comb begin
    diff   = btn_d ^ btn_q;
    xfer   = vld_q & chg_ready;
    mask_d = (xfer ? 16'h0000 : mask_q) | diff;
    vld_d  = (vld_q & ~xfer) | (|diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= 3'd0;
      cnt_q   <= 8'd0;
      frame_q <= 16'h0000;
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      btn_q   <= 16'h0000;
      mask_q  <= 16'h0000;
      vld_q   <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
      last_q  <= 16'h0000;
      match_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      btn_q   <= btn_d;
      mask_q  <= mask_d;
      vld_q   <= vld_d;
`ifdef GAMEPAD_DEBOUNCE_EN
      last_q  <= last_d;
      match_q <= match_d;
`endif
    end
  end

  assign row_sel    = row_q;
  assign dec_enable = (state_q == ST_DRIVE);
  assign busy       = (state_q != ST_IDLE);
  assign btn_state  = btn_q;
  assign chg_mask   = mask_q;
  assign chg_valid  = vld_q;

endmodule

// File: tb/tb_gamepad_scanner.sv
// Bench for gamepad_scanner: frame-schedule reference model compared every cycle,
// directed scenarios with literal expectations, then randomized key/ready/scan_en/reset traffic.
module tb_gamepad_scanner;
  localparam int S       = 3;
  localparam int DEB     = 2;
  localparam int ROWLEN  = S + 2;
  localparam int FRAME_T = 8 * ROWLEN;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        chg_ready;
  logic [1:0]  col_in;
  logic [2:0]  row_sel;
  logic        dec_enable;
  logic [15:0] btn_state;
  logic        chg_valid;
  logic [15:0] chg_mask;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] keys = 16'h0000;
  bit          noise_en = 1'b0;
  bit          check_en = 1'b0;

  gamepad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .row_sel(row_sel),
    .dec_enable(dec_enable), .col_in(col_in), .btn_state(btn_state),
    .chg_valid(chg_valid), .chg_ready(chg_ready), .chg_mask(chg_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  // Physical matrix: the selected row shows its two keys on the column lines.
  initial col_in = 2'b00;
  always @(posedge clk) begin
    #2;
    col_in = (dec_enable === 1'b1) ? keys[{row_sel, 1'b0} +: 2] : 2'b00;
    if (noise_en && $urandom_range(0, 15) == 0) col_in = 2'($urandom);
  end

  // Reference model: position within the frame is a plain cycle count.
  bit          m_busy = 1'b0;
  int          m_t = 0;
  logic [15:0] m_frame = 16'h0, m_btn = 16'h0, m_mask = 16'h0, m_prev = 16'h0;
  bit          m_vld = 1'b0, m_have_prev = 1'b0;
  int          m_run = 0;
  logic [1:0]  m_h1 = 2'b00, m_h2 = 2'b00;

  always @(posedge clk) begin : model
    logic [15:0] nb, d;
    bit xfer;
    if (rst) begin
      m_busy = 0; m_t = 0; m_frame = 0; m_btn = 0; m_mask = 0; m_vld = 0;
      m_prev = 0; m_have_prev = 0; m_run = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      xfer = m_vld && chg_ready;
      d = 16'h0;
      if (m_busy) begin
        if (m_t == FRAME_T) begin
          if (m_have_prev && m_frame == m_prev) m_run++;
          else m_run = 1;
          m_prev = m_frame;
          m_have_prev = 1;
`ifdef GAMEPAD_DEBOUNCE_EN
          nb = (m_run >= DEB) ? m_frame : m_btn;
`else
          nb = m_frame;
`endif
          d = nb ^ m_btn;
          m_btn = nb;
          if (scan_en) m_t = 0;
          else m_busy = 0;
        end else begin
          if (m_t % ROWLEN == S) m_frame[2 * (m_t / ROWLEN) +: 2] = m_h2;
          m_t++;
        end
      end else if (scan_en) begin
        m_busy = 1;
        m_t = 0;
      end
      if (xfer) begin m_mask = 0; m_vld = 0; end
      if (d != 0) begin m_mask |= d; m_vld = 1; end
      m_h2 = m_h1;
      m_h1 = col_in;
    end
  end

  always @(negedge clk) begin : compare
    logic       e_dec;
    logic [2:0] e_row;
    if (check_en) begin
      e_dec = m_busy && (m_t < FRAME_T) && ((m_t % ROWLEN) < S);
      e_row = m_busy ? 3'(m_t / ROWLEN) : 3'd0;
      checks++;
      if (btn_state !== m_btn || chg_mask !== m_mask || chg_valid !== m_vld ||
          busy !== m_busy || dec_enable !== e_dec ||
          ((e_dec || !m_busy) && row_sel !== e_row)) begin
        errors++;
        $display("FAIL cycle_compare @%0t dut/model btn=%h/%h mask=%h/%h vld=%b/%b busy=%b/%b dec=%b/%b row=%0d/%0d",
                 $time, btn_state, m_btn, chg_mask, m_mask, chg_valid, m_vld,
                 busy, m_busy, dec_enable, e_dec, row_sel, e_row);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for DUT", name);
  endtask

  // Returns in the first cycle of the frame following the next FRAME cycle.
  task automatic next_frame_start();
    int n = 0;
    while (!(m_busy && m_t == FRAME_T)) begin
      @(posedge clk); #1;
      if (++n > 200) begin timeout("frame_wait"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_row(input logic [2:0] r);
    int n = 0;
    while (!(dec_enable === 1'b1 && row_sel == r)) begin
      @(posedge clk); #1;
      if (++n > 200) begin timeout("row_wait"); return; end
    end
  endtask

  initial begin : main
    int  len, max_row, per_row[8];
    bit  seen7;
    rst = 1'b1; scan_en = 1'b0; chg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {btn_state, chg_mask, chg_valid, busy, dec_enable, row_sel}, 64'h0);

    // Idle scanning with no keys: row stepping and frame period.
    @(posedge clk); #1 rst = 1'b0; scan_en = 1'b1;
    next_frame_start();
    len = 0; seen7 = 0;
    foreach (per_row[i]) per_row[i] = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dec_enable && row_sel == 3'd0 && seen7) begin len = i; break; end
      if (dec_enable) begin
        per_row[row_sel]++;
        if (row_sel == 3'd7) seen7 = 1;
      end
    end
    chk("frame_period", 64'(len), 64'd41);
    for (int r = 0; r < 8; r++) chk("row_hold_cycles", 64'(per_row[r]), 64'd3);
    chk("idle_btn", 64'(btn_state), 64'h0);

    // Row 5 column 1 held for two frames.
    next_frame_start();
    keys = 16'h0800;
    next_frame_start();
    next_frame_start();
    @(negedge clk);
    chk("press11_btn", 64'(btn_state), 64'h0800);
    chk("press11_report", {chg_valid, chg_mask}, {1'b1, 16'h0800});

    // Release 11, press 0 while the report stays unaccepted.
    keys = 16'h0001;
    next_frame_start();
    next_frame_start();
    @(negedge clk);
    chk("swap_btn", 64'(btn_state), 64'h0001);
    chk("swap_report", {chg_valid, chg_mask}, {1'b1, 16'h0801});
    @(posedge clk); #1 chg_ready = 1'b1;
    @(negedge clk);
    chk("xfer_cycle_report", {chg_valid, chg_mask}, {1'b1, 16'h0801});
    @(posedge clk); #1 chg_ready = 1'b0;
    @(negedge clk);
    chk("after_xfer_report", {chg_valid, chg_mask}, {1'b0, 16'h0000});

    // One-frame glitch on bit 3.
    next_frame_start();
    keys = 16'h0009;
    next_frame_start();
    keys = 16'h0001;
    @(negedge clk);
`ifdef GAMEPAD_DEBOUNCE_EN
    chk("glitch_btn", 64'(btn_state), 64'h0001);
    chk("glitch_valid", 64'(chg_valid), 64'h0);
`else
    chk("glitch_btn", 64'(btn_state), 64'h0009);
    chk("glitch_report", {chg_valid, chg_mask}, {1'b1, 16'h0008});
`endif
    next_frame_start();
    @(negedge clk);
`ifdef GAMEPAD_DEBOUNCE_EN
    chk("glitch_after_btn", 64'(btn_state), 64'h0001);
    chk("glitch_after_valid", 64'(chg_valid), 64'h0);
`else
    chk("glitch_after_btn", 64'(btn_state), 64'h0001);
    chk("glitch_after_report", {chg_valid, chg_mask}, {1'b1, 16'h0008});
`endif

    // Reset in row 4 with a report pending.
    keys = 16'h0000;
    next_frame_start();
    next_frame_start();
    @(negedge clk);
    chk("pending_before_rst", 64'(chg_valid), 64'h1);
    wait_row(3'd4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_frame", {btn_state, chg_mask, chg_valid, busy, dec_enable, row_sel}, 64'h0);
    @(negedge clk);
    chk("restart_drive", {busy, dec_enable, row_sel}, {1'b1, 1'b1, 3'd0});

    // Drop scan_en in row 2: frame completes and is evaluated.
    keys = 16'h4000;
    next_frame_start();
    wait_row(3'd2);
    scan_en = 1'b0;
    max_row = 0;
    len = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dec_enable && int'(row_sel) > max_row) max_row = int'(row_sel);
      if (!busy) begin len = i; break; end
    end
    if (len < 0) timeout("stop_to_idle");
    chk("stop_last_row", 64'(max_row), 64'd7);
    chk("stop_btn", 64'(btn_state), 64'h4000);
    chk("stop_idle", {busy, dec_enable, row_sel}, 64'h0);
    repeat (5) @(negedge clk);
    chk("stays_idle", 64'(busy), 64'h0);

    // Randomized traffic.
    noise_en = 1'b1;
    @(posedge clk); #1 scan_en = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      chg_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) keys = 16'($urandom & $urandom);
      if ($urandom_range(0, 399) == 0) scan_en = ~scan_en;
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
